// File: rtl/opb_register_simulink2ppc_capture_pkg.sv
// Shared constants for the fabric-to-PPC capture register: word offsets,
// status bit layout (numeric, bit 0 = OPB bit 31) and the bus FSM states.
package opb_register_simulink2ppc_capture_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_TSTAMP = 2'd2;

    localparam int STAT_NEW_BIT = 0;
    localparam int STAT_OVR_BIT = 1;
    localparam int STAT_CNT_LSB = 16;
    localparam int STAT_CNT_W   = 16;

    // Clear requests carried in a STATUS write (OPB bits 30 and 29)
    localparam int CLR_OVR_BIT = 1;
    localparam int CLR_CNT_BIT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        GUARD
    } state_t;

    function automatic logic [31:0] pack_status(input logic             new_flag,
                                                input logic             ovr_flag,
                                                input logic [STAT_CNT_W-1:0] cnt);
        logic [31:0] w;
        w = '0;
        w[STAT_NEW_BIT] = new_flag;
        w[STAT_OVR_BIT] = ovr_flag;
        w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_capture_s2p_capture_reg.sv
// Capture holding register: DATA, new/overrun flags, capture count and,
// when S2P_TIMESTAMP_EN is defined, a cycle-counter timestamp per capture.
module s2p_capture_reg
    import opb_register_simulink2ppc_capture_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cap_valid_i,
    input  logic [31:0]           cap_data_i,
    input  logic                  rd_data_i,
    input  logic                  clr_ovr_i,
    input  logic                  clr_cnt_i,
    output logic [31:0]           data_o,
    output logic                  new_o,
    output logic                  overrun_o,
    output logic [STAT_CNT_W-1:0] count_o,
    output logic [31:0]           tstamp_o
);

    logic [31:0]           data_q, data_d;
    logic                  new_q, new_d;
    logic                  ovr_q, ovr_d;
    logic [STAT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        data_d = cap_valid_i ? cap_data_i : data_q;
        // A capture racing a DATA read keeps new set; the read consumed the old word
        new_d  = cap_valid_i ? 1'b1 : (rd_data_i ? 1'b0 : new_q);
        ovr_d  = ovr_q;
        if (cap_valid_i && new_q && !rd_data_i) begin
            ovr_d = 1'b1;
        end
        if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
        cnt_d = (clr_cnt_i ? '0 : cnt_q) + {{(STAT_CNT_W-1){1'b0}}, cap_valid_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            new_q  <= 1'b0;
            ovr_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            new_q  <= new_d;
            ovr_q  <= ovr_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef S2P_TIMESTAMP_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] tstamp_q, tstamp_d;

    always_comb begin
        cycle_d  = cycle_q + 32'd1;
        tstamp_d = cap_valid_i ? cycle_q : tstamp_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_q  <= '0;
            tstamp_q <= '0;
        end else begin
            cycle_q  <= cycle_d;
            tstamp_q <= tstamp_d;
        end
    end

    assign tstamp_o = tstamp_q;
`else
    assign tstamp_o = '0;
`endif

    assign data_o    = data_q;
    assign new_o     = new_q;
    assign overrun_o = ovr_q;
    assign count_o   = cnt_q;

endmodule

// File: rtl/opb_register_simulink2ppc_capture.sv
// OPB slave carrying fabric words to the PowerPC: address decode, ack FSM and
// read mux. Optional capture timestamp enabled by S2P_TIMESTAMP_EN.
module opb_register_simulink2ppc_capture
    import opb_register_simulink2ppc_capture_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01014500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010145FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    input  logic [31:0] user_data_in,
    input  logic        user_data_valid
);

    localparam int unused_params = C_OPB_AWIDTH + C_OPB_DWIDTH + $bits(C_FAMILY);

    state_t      state_q;
    logic        ack_q;
    logic [31:0] dbus_q;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  word_off;
    logic        hit, idle_hit, rd_data_stb, wr_status;
    logic [31:0] rd_mux;

    logic [31:0]           cap_data;
    logic                  cap_new, cap_ovr;
    logic [STAT_CNT_W-1:0] cap_cnt;
    logic [31:0]           cap_tstamp;

    assign addr     = OPB_ABus;
    assign wdata    = OPB_DBus;
    assign word_off = OPB_ABus[28:29];

    assign hit         = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign idle_hit    = (state_q == IDLE) && hit;
    assign rd_data_stb = idle_hit && OPB_RNW && (word_off == OFF_DATA);
    assign wr_status   = idle_hit && !OPB_RNW && (word_off == OFF_STATUS) && OPB_BE[3];

    s2p_capture_reg u_capture (
        .clk_i       (OPB_Clk),
        .rst_i       (OPB_Rst),
        .cap_valid_i (user_data_valid),
        .cap_data_i  (user_data_in),
        .rd_data_i   (rd_data_stb),
        .clr_ovr_i   (wr_status && wdata[CLR_OVR_BIT]),
        .clr_cnt_i   (wr_status && wdata[CLR_CNT_BIT]),
        .data_o      (cap_data),
        .new_o       (cap_new),
        .overrun_o   (cap_ovr),
        .count_o     (cap_cnt),
        .tstamp_o    (cap_tstamp)
    );

    always_comb begin
        rd_mux = '0;
        case (word_off)
            OFF_DATA:   rd_mux = cap_data;
            OFF_STATUS: rd_mux = pack_status(cap_new, cap_ovr, cap_cnt);
            OFF_TSTAMP: rd_mux = cap_tstamp;
            default:    rd_mux = '0;
        endcase
    end

    // GUARD holds off a second ack while a master keeps select asserted
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dbus_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        dbus_q  <= OPB_RNW ? rd_mux : '0;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    dbus_q  <= '0;
                    ack_q   <= 1'b0;
                    state_q <= GUARD;
                end
                GUARD: begin
                    if (!OPB_select) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:3], wdata[0]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_capture.sv
// Directed bench for the OPB capture register with hand-computed expectations.
module tb_opb_register_simulink2ppc_capture;

    localparam logic [31:0] BASE = 32'h01014500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:31] abus = '0;
    logic [0:3]  be = '0;
    logic [0:31] dbus = '0;
    logic        rnw = 1'b0;
    logic        sel = 1'b0;
    logic        seq = 1'b0;
    logic [0:31] sl_dbus;
    logic        sl_ack, sl_err, sl_retry, sl_tout;
    logic [31:0] udata = '0;
    logic        uvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_capture dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst),
        .OPB_ABus        (abus),
        .OPB_BE          (be),
        .OPB_DBus        (dbus),
        .OPB_RNW         (rnw),
        .OPB_select      (sel),
        .OPB_seqAddr     (seq),
        .Sl_DBus         (sl_dbus),
        .Sl_xferAck      (sl_ack),
        .Sl_errAck       (sl_err),
        .Sl_retry        (sl_retry),
        .Sl_toutSup      (sl_tout),
        .user_data_in    (udata),
        .user_data_valid (uvalid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Read data must be zero whenever no acknowledge is present
    always @(negedge clk) begin
        if (!sl_ack) chk("dbus_nonack", sl_dbus, 32'h0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic opb_xfer(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                            input logic [3:0] ben, input logic cap, input logic [31:0] cdata,
                            output logic [31:0] rdata);
        int lat;
        @(negedge clk);
        abus = addr; rnw = rd; dbus = wd; be = ben; sel = 1'b1;
        if (cap) begin
            udata = cdata;
            uvalid = 1'b1;
        end
        lat = 0;
        rdata = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            uvalid = 1'b0;
            if (sl_ack) begin
                lat = i;
                rdata = sl_dbus;
                break;
            end
        end
        sel = 1'b0;
        chk("ack_latency", lat, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        opb_xfer(addr, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, data);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] ben);
        logic [31:0] dummy;
        opb_xfer(addr, 1'b0, data, ben, 1'b0, 32'h0, dummy);
    endtask

    task automatic cap_n(input logic [31:0] data, input int n);
        @(negedge clk);
        udata = data;
        uvalid = 1'b1;
        repeat (n) @(negedge clk);
        uvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int acks;

        // 1: reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ack", sl_ack, 1'b0);
        chk("rst_dbus", sl_dbus, 32'h0);
        chk("tied_zero", {29'h0, sl_err, sl_retry, sl_tout}, 32'h0);
        rd(BASE + 32'h4, r); chk("rst_status", r, 32'h0);
        rd(BASE + 32'h0, r); chk("rst_data", r, 32'h0);

        // 2: single capture, DATA read clears new, DATA writes ignored
        cap_n(32'hDEADBEEF, 1);
        rd(BASE + 32'h0, r); chk("data_read", r, 32'hDEADBEEF);
        rd(BASE + 32'h4, r); chk("status_after_read", r, 32'h00010000);
        wr(BASE + 32'h0, 32'h12345678, 4'hF);
        rd(BASE + 32'h0, r); chk("data_write_ignored", r, 32'hDEADBEEF);
        rd(BASE + 32'hC, r); chk("off_c_zero", r, 32'h0);

        // 3: overrun, clears, capture racing clears
        do_reset();
        cap_n(32'h1, 1);
        cap_n(32'h2, 1);
        rd(BASE + 32'h4, r); chk("overrun_set", r, 32'h00020003);
        wr(BASE + 32'h4, 32'h2, 4'hF);
        rd(BASE + 32'h4, r); chk("overrun_clr", r, 32'h00020001);
        wr(BASE + 32'h4, 32'h4, 4'hF);
        rd(BASE + 32'h4, r); chk("count_clr", r, 32'h00000001);
        opb_xfer(BASE + 32'h4, 1'b0, 32'h6, 4'hF, 1'b1, 32'h7, r);
        rd(BASE + 32'h4, r); chk("clr_with_cap", r, 32'h00010001);

        // 4: capture in the DATA-read sample cycle
        cap_n(32'h4, 1);
        wr(BASE + 32'h4, 32'h2, 4'hE);
        rd(BASE + 32'h4, r); chk("status_be3_off", r, 32'h00020003);
        wr(BASE + 32'h4, 32'h2, 4'hF);
        rd(BASE + 32'h0, r); chk("data_prior", r, 32'h4);
        opb_xfer(BASE + 32'h0, 1'b1, 32'h0, 4'hF, 1'b1, 32'h5, r);
        chk("race_old_data", r, 32'h4);
        rd(BASE + 32'h4, r); chk("race_status", r, 32'h00030001);
        rd(BASE + 32'h0, r); chk("race_new_data", r, 32'h5);

        // 5: held select gives one ack; window boundaries
        @(negedge clk);
        abus = BASE + 32'h4; rnw = 1'b1; sel = 1'b1; acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        chk("held_select_acks", acks, 1);
        abus = 32'h01014600; sel = 1'b1; acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        abus = 32'h010144FC;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        sel = 1'b0;
        chk("outside_acks", acks, 0);
        rd(32'h010145FF, r); chk("top_of_window", r, 32'h0);
        rd(32'h01014503, r); chk("byte_bits_ignored", r, 32'h5);

        // reset during an acknowledge drops it immediately
        @(negedge clk);
        abus = BASE + 32'h0; rnw = 1'b1; sel = 1'b1;
        @(posedge clk); #1;
        chk("ack_pre_reset", sl_ack, 1'b1);
        rst = 1'b1; #1;
        chk("ack_mid_reset", sl_ack, 1'b0);
        chk("dbus_mid_reset", sl_dbus, 32'h0);
        @(negedge clk);
        sel = 1'b0; rst = 1'b0;

        // 6: count wrap and timestamp
        do_reset();
        cap_n(32'hA5A50000, 65535);
        rd(BASE + 32'h4, r); chk("count_ffff", r, 32'hFFFF0003);
        cap_n(32'hA5A50001, 1);
        rd(BASE + 32'h4, r); chk("count_wrap", r, 32'h00000003);
        rd(BASE + 32'h0, r); chk("wrap_data", r, 32'hA5A50001);

        do_reset();
        repeat (100) @(negedge clk);
        udata = 32'h77;
        uvalid = 1'b1;
        @(negedge clk);
        uvalid = 1'b0;
        rd(BASE + 32'h8, r);
`ifdef S2P_TIMESTAMP_EN
        chk("timestamp", r, 32'd100);
`else
        chk("timestamp", r, 32'd0);
`endif
        rd(BASE + 32'h4, r); chk("ts_status", r, 32'h00010001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
